// File: rtl/maze_pkg.sv
// Shared constants and types for the maze sprite collision path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package maze_pkg;

  localparam int TILE_SHIFT    = 4;    // 16x16 pixel tiles
  localparam int MAP_COLS      = 40;
  localparam int MAP_ROWS      = 30;
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int BOUNCE_FRAMES = 8;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    WAIT,
    DECIDE,
    BOUNCE
  } collide_state_t;

  typedef enum logic [1:0] {
    DIR_L,
    DIR_R,
    DIR_U,
    DIR_D
  } dir_t;

  // Probe point idx (0,1,2) just beyond the leading edge for travel direction dir.
  // Returns {x, y}; all arithmetic wraps at 10 bits so x-1 / y-1 at 0 lands at 1023,
  // which the tile calculator then flags as off-screen.
  function automatic logic [19:0] probe_point(input dir_t       dir,
                                               input logic [1:0] idx,
                                               input logic [9:0] xp,
                                               input logic [9:0] yp,
                                               input logic [9:0] w,
                                               input logic [9:0] h);
    logic [9:0] off_w;
    logic [9:0] off_h;
    logic [9:0] px;
    logic [9:0] py;
    case (idx)
      2'd0: begin
        off_w = 10'd0;
        off_h = 10'd0;
      end
      2'd1: begin
        off_w = w >> 1;
        off_h = h >> 1;
      end
      default: begin
        off_w = w;
        off_h = h;
      end
    endcase
    case (dir)
      DIR_R: begin
        px = xp + w + 10'd1;
        py = yp + off_h;
      end
      DIR_L: begin
        px = xp - 10'd1;
        py = yp + off_h;
      end
      DIR_D: begin
        px = xp + off_w;
        py = yp + h + 10'd1;
      end
      default: begin
        px = xp + off_w;
        py = yp - 10'd1;
      end
    endcase
    return {px, py};
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Maps a pixel coordinate to its tile-map index and flags off-screen points.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y (pixel coordinate in) -> map_addr (row*MAP_COLS+col), oob (off-screen).
module tile_addr_calc
  import maze_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [10:0] map_addr,
  output logic        oob
);

  // Off-screen coordinates still yield an address (mod 2048); callers use oob
  // to decide whether the map contents matter.
  always_comb begin
    map_addr = 11'(y[9:TILE_SHIFT]) * 11'(MAP_COLS) + 11'(x[9:TILE_SHIFT]);
    oob      = (x >= 10'(SCREEN_W)) || (y >= 10'(SCREEN_H));
  end

endmodule

// File: rtl/maze_collider.sv
// Per-frame wall-collision detector: probes 3 tile-map points ahead of the sprite and
// holds the opposite bounce request for BOUNCE_FRAMES frames on a hit.
// Latency: bounce bit registered 5 Clk after the internal frame_rise pulse; no backpressure.
// Ports: Clk/Reset; frame_clk, spr_on, inc controls; sprite pos/size/direction in;
//        map_addr/map_rdata to the tile ROM (1-cycle read); bnceL/R/U/D, busy, wall_hits out.
module maze_collider
  import maze_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        spr_on,
  input  logic        inc,
  input  logic [9:0]  sprite_xpos,
  input  logic [9:0]  sprite_ypos,
  input  logic [9:0]  sprite_W,
  input  logic [9:0]  sprite_H,
  input  logic        L,
  input  logic        R,
  input  logic        U,
  input  logic        D,
  output logic [10:0] map_addr,
  input  logic        map_rdata,
  output logic        bnceL,
  output logic        bnceR,
  output logic        bnceU,
  output logic        bnceD,
  output logic        busy,
  output logic [7:0]  wall_hits
);

  collide_state_t state;
  dir_t           dir_q;
  dir_t           dir_sel;
  logic [9:0]     xp_q, yp_q, w_q, h_q;
  logic [1:0]     idx_q;
  logic           addr_oob_q;   // oob flag of the address currently on map_addr
  logic           data_vld_q;   // map_rdata this cycle belongs to an on-screen probe
  logic           hit_q;
  logic [3:0]     bnce_cnt;
  logic [3:0]     bnce_q;       // {L, R, U, D}
  logic           frame_d;
  logic           frame_rise;
  logic           any_dir;

  // Next-probe source: raw inputs when launching from IDLE, latched values after.
  dir_t           src_dir;
  logic [1:0]     src_idx;
  logic [9:0]     src_x, src_y, src_w, src_h;
  logic [19:0]    probe_xy;
  logic [10:0]    nxt_addr;
  logic           nxt_oob;

  assign any_dir = L | R | U | D;

  always_comb begin
    dir_sel = DIR_D;
    if (L)      dir_sel = DIR_L;
    else if (R) dir_sel = DIR_R;
    else if (U) dir_sel = DIR_U;
  end

  always_comb begin
    src_dir = dir_q;
    src_idx = 2'(idx_q + 2'd1);
    src_x   = xp_q;
    src_y   = yp_q;
    src_w   = w_q;
    src_h   = h_q;
    if (state == IDLE) begin
      src_dir = dir_sel;
      src_idx = 2'd0;
      src_x   = sprite_xpos;
      src_y   = sprite_ypos;
      src_w   = sprite_W;
      src_h   = sprite_H;
    end
    probe_xy = probe_point(src_dir, src_idx, src_x, src_y, src_w, src_h);
  end

  tile_addr_calc u_tile_addr_calc (
    .x        (probe_xy[19:10]),
    .y        (probe_xy[9:0]),
    .map_addr (nxt_addr),
    .oob      (nxt_oob)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      dir_q      <= DIR_L;
      xp_q       <= '0;
      yp_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      idx_q      <= '0;
      addr_oob_q <= 1'b0;
      data_vld_q <= 1'b0;
      hit_q      <= 1'b0;
      bnce_cnt   <= '0;
      bnce_q     <= '0;
      map_addr   <= '0;
      wall_hits  <= '0;
      frame_d    <= 1'b0;
      frame_rise <= 1'b0;
    end else begin
      frame_d    <= frame_clk;
      frame_rise <= frame_clk & ~frame_d;

      if (!spr_on || inc) begin
        // Abort: drop any probe in flight and release the bounce; wall_hits survives.
        state      <= IDLE;
        bnce_q     <= '0;
        bnce_cnt   <= '0;
        data_vld_q <= 1'b0;
        hit_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_rise && any_dir) begin
              dir_q      <= dir_sel;
              xp_q       <= sprite_xpos;
              yp_q       <= sprite_ypos;
              w_q        <= sprite_W;
              h_q        <= sprite_H;
              idx_q      <= 2'd0;
              map_addr   <= nxt_addr;
              addr_oob_q <= nxt_oob;
              data_vld_q <= 1'b0;
              hit_q      <= 1'b0;
              state      <= PROBE;
            end
          end
          PROBE: begin
            // An off-screen address is a hit on its own; its ROM data is never used.
            hit_q      <= hit_q | addr_oob_q | (data_vld_q & map_rdata);
            data_vld_q <= ~addr_oob_q;
            if (idx_q == 2'd2) begin
              state <= WAIT;
            end else begin
              idx_q      <= 2'(idx_q + 2'd1);
              map_addr   <= nxt_addr;
              addr_oob_q <= nxt_oob;
            end
          end
          WAIT: begin
            hit_q      <= hit_q | (data_vld_q & map_rdata);
            data_vld_q <= 1'b0;
            state      <= DECIDE;
          end
          DECIDE: begin
            if (hit_q) begin
              state    <= BOUNCE;
              bnce_cnt <= 4'(BOUNCE_FRAMES);
              case (dir_q)
                DIR_L:   bnce_q <= 4'b0100;
                DIR_R:   bnce_q <= 4'b1000;
                DIR_U:   bnce_q <= 4'b0001;
                default: bnce_q <= 4'b0010;
              endcase
              if (wall_hits != 8'hFF) wall_hits <= wall_hits + 8'd1;
            end else begin
              state <= IDLE;
            end
          end
          BOUNCE: begin
            if (frame_rise) begin
              if (bnce_cnt <= 4'd1) begin
                bnce_cnt <= '0;
                bnce_q   <= '0;
                state    <= IDLE;
              end else begin
                bnce_cnt <= bnce_cnt - 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign {bnceL, bnceR, bnceU, bnceD} = bnce_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_maze_collider.sv
// Directed bench for maze_collider with a 1-cycle-latency tile ROM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_maze_collider;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        spr_on;
  logic        inc;
  logic [9:0]  sprite_xpos;
  logic [9:0]  sprite_ypos;
  logic [9:0]  sprite_W;
  logic [9:0]  sprite_H;
  logic        L, R, U, D;
  logic [10:0] map_addr;
  logic        map_rdata;
  logic        bnceL, bnceR, bnceU, bnceD;
  logic        busy;
  logic [7:0]  wall_hits;
  logic [3:0]  bnce;

  int checks;
  int failures;

  logic wall [0:2047];

  maze_collider dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .spr_on      (spr_on),
    .inc         (inc),
    .sprite_xpos (sprite_xpos),
    .sprite_ypos (sprite_ypos),
    .sprite_W    (sprite_W),
    .sprite_H    (sprite_H),
    .L           (L),
    .R           (R),
    .U           (U),
    .D           (D),
    .map_addr    (map_addr),
    .map_rdata   (map_rdata),
    .bnceL       (bnceL),
    .bnceR       (bnceR),
    .bnceU       (bnceU),
    .bnceD       (bnceD),
    .busy        (busy),
    .wall_hits   (wall_hits)
  );

  assign bnce = {bnceL, bnceR, bnceU, bnceD};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Tile ROM: data for the address presented in one cycle appears the next.
  always @(posedge Clk) map_rdata <= wall[map_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One probed frame: frame_clk rises at a negedge; the registered rise pulse is
  // consumed at the 2nd posedge, so the three addresses show after posedges 2..4
  // and the bounce bit after posedge 7.
  task automatic probe_frame(input string tag, input logic [10:0] a0, input logic [10:0] a1,
                             input logic [10:0] a2, input logic [3:0] exp_b);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 chk({tag, "_addr0"}, 32'(map_addr), 32'(a0));
    chk({tag, "_busy_probe"}, 32'(busy), 32'd1);
    @(posedge Clk);
    #1 chk({tag, "_addr1"}, 32'(map_addr), 32'(a1));
    @(posedge Clk);
    #1 chk({tag, "_addr2"}, 32'(map_addr), 32'(a2));
    repeat (2) @(posedge Clk);
    #1 chk({tag, "_bnce_early"}, 32'(bnce), 32'd0);
    @(posedge Clk);
    #1 chk({tag, "_bnce"}, 32'(bnce), 32'(exp_b));
    chk({tag, "_busy_after"}, 32'(busy), (exp_b != 4'd0) ? 32'd1 : 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic frame_pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic inc_pulse();
    @(negedge Clk) inc = 1'b1;
    @(negedge Clk) inc = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    for (int i = 0; i < 2048; i++) wall[i] = 1'b0;
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    spr_on      = 1'b1;
    inc         = 1'b0;
    sprite_xpos = 10'd0;
    sprite_ypos = 10'd0;
    sprite_W    = 10'd0;
    sprite_H    = 10'd0;
    {L, R, U, D} = 4'b0000;

    // Reset state
    repeat (3) @(posedge Clk);
    #1 chk("rst_addr", 32'(map_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bnce", 32'(bnce), 32'd0);
    chk("rst_hits", 32'(wall_hits), 32'd0);
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // 1: open field moving right; probe x=357 (col 22), y=33,43,53 (rows 2,2,3)
    R = 1'b1; sprite_xpos = 10'd336; sprite_ypos = 10'd33;
    sprite_W = 10'd20; sprite_H = 10'd20;
    probe_frame("t1", 11'd102, 11'd102, 11'd142, 4'b0000);
    chk("t1_hits", 32'(wall_hits), 32'd0);
    chk("t1_addr_hold", 32'(map_addr), 32'd142);

    // 2: wall at col 22 row 2; xpos=332 -> x=353 -> bnceL for 8 frames
    wall[102] = 1'b1;
    sprite_xpos = 10'd332;
    probe_frame("t2", 11'd102, 11'd102, 11'd142, 4'b1000);
    chk("t2_hits", 32'(wall_hits), 32'd1);
    L = 1'b1;  // direction change during bounce must be ignored
    for (int i = 0; i < 7; i++) frame_pulse();
    chk("t2_bnce_held7", 32'(bnce), 32'b1000);
    chk("t2_busy_held7", 32'(busy), 32'd1);
    frame_pulse();
    chk("t2_bnce_released", 32'(bnce), 32'd0);
    chk("t2_busy_released", 32'(busy), 32'd0);
    chk("t2_hits_after", 32'(wall_hits), 32'd1);
    L = 1'b0;
    wall[102] = 1'b0;

    // 3: up at ypos=0 -> y wraps to 1023 (row 63); cols 6,6,7; addr mod 2048
    R = 1'b0; U = 1'b1;
    sprite_xpos = 10'd100; sprite_ypos = 10'd0;
    probe_frame("t3", 11'd478, 11'd478, 11'd479, 4'b0001);
    chk("t3_hits", 32'(wall_hits), 32'd2);
    @(negedge Clk) inc = 1'b1;
    @(posedge Clk);
    #1 chk("t3_inc_bnce", 32'(bnce), 32'd0);
    chk("t3_inc_busy", 32'(busy), 32'd0);
    chk("t3_inc_hits", 32'(wall_hits), 32'd2);
    @(negedge Clk) inc = 1'b0;

    // 4: down, y=121 (row 7), x=200,220,240 (cols 12,13,15); wall only at midpoint
    U = 1'b0; D = 1'b1;
    sprite_xpos = 10'd200; sprite_ypos = 10'd100;
    sprite_W = 10'd40; sprite_H = 10'd20;
    wall[293] = 1'b1;
    probe_frame("t4", 11'd292, 11'd293, 11'd295, 4'b0010);
    chk("t4_hits", 32'(wall_hits), 32'd3);

    // 5a: spr_on drops during bounce frame 3
    frame_pulse();
    frame_pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    spr_on = 1'b0;
    @(posedge Clk);
    #1 chk("t5_spr_bnce", 32'(bnce), 32'd0);
    chk("t5_spr_busy", 32'(busy), 32'd0);
    chk("t5_spr_hits", 32'(wall_hits), 32'd3);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    spr_on = 1'b1;
    wall[293] = 1'b0;

    // 5b: Reset mid-probe
    D = 1'b0; R = 1'b1;
    sprite_xpos = 10'd336; sprite_ypos = 10'd33;
    sprite_W = 10'd20; sprite_H = 10'd20;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 chk("t5_rst_busy_before", 32'(busy), 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    #1 chk("t5_rst_addr", 32'(map_addr), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_bnce", 32'(bnce), 32'd0);
    chk("t5_rst_hits", 32'(wall_hits), 32'd0);
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // 6: 300 forced off-screen hits saturate wall_hits
    R = 1'b0; U = 1'b1;
    sprite_xpos = 10'd100; sprite_ypos = 10'd0;
    for (int i = 0; i < 299; i++) begin
      frame_pulse();
      inc_pulse();
      if (i == 253) chk("t6_hits_254", 32'(wall_hits), 32'd254);
    end
    frame_pulse();
    chk("t6_bnce_last", 32'(bnce), 32'b0001);
    chk("t6_hits_sat", 32'(wall_hits), 32'd255);
    @(negedge Clk) inc = 1'b1;
    @(posedge Clk);
    #1 chk("t6_inc_bnce", 32'(bnce), 32'd0);
    chk("t6_inc_hits", 32'(wall_hits), 32'd255);
    @(negedge Clk) inc = 1'b0;
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
